// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: opcodes and FSM states shared by the SPI command sequencer.
// The opcode values are mirrored in the MCU firmware header.
package spi_cmd_pkg;
    localparam logic [3:0] OP_WRITE_AT   = 4'h8;
    localparam logic [3:0] OP_READ_AT    = 4'h4;
    localparam logic [3:0] OP_WRITE_NEXT = 4'h2;
    localparam logic [3:0] OP_READ_NEXT  = 4'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_BUS,
        S_DONE
    } spi_cmd_state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer, resets to 1 (idle level of an active-low select).
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta, r_q;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) {r_q, r_meta} <= 2'b11;
        else       {r_q, r_meta} <= {r_meta, i_d};

    assign o_q = r_q;
endmodule

// File: rtl/spi_cmd.sv
// spi_cmd: decodes SPI command frames into single read/write bus cycles and
// returns read data as the next byte for the SPI shifter.
module spi_cmd
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  spi_cs_n,
    input  logic [7:0]            spi_rx_byte,
    input  logic                  spi_valid,
    output logic [7:0]            spi_tx_byte,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wr_data,
    output logic                  bus_rw_b,
    output logic                  bus_req,
    input  logic                  bus_ack,
    input  logic [7:0]            bus_rd_data,
    output logic                  busy,
    output logic                  overrun
);
    spi_cmd_state_t r_state, w_state_nx;
    logic                  w_cs_s, r_cs_d, w_start, w_take;
    logic [3:0]            w_op;
    logic                  r_at, r_wr, r_req, r_rw_b, r_overrun;
    logic                  w_issue, w_iss_rd;
    logic [ADDR_WIDTH-1:0] r_tmp, r_addr, w_iss_addr, w_next_addr;
    logic [7:0]            r_wr_data, r_tx;

    sync2 u_sync (.i_clk(sys_clk), .i_rst(reset), .i_d(spi_cs_n), .o_q(w_cs_s));

    assign w_start     = r_cs_d & ~w_cs_s;
    assign w_take      = spi_valid & ~w_cs_s & ~w_start & (r_state != S_BUS);
    assign w_op        = spi_rx_byte[7:4];
    assign w_next_addr = r_addr + 1'b1;

    always_ff @(posedge sys_clk or posedge reset)
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;

    // A pending bus cycle always finishes before the frame state is touched.
    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        w_iss_rd   = 1'b1;
        w_iss_addr = r_addr;
        if (r_state == S_BUS) begin
            if (bus_ack) w_state_nx = w_cs_s ? S_IDLE : S_CMD;
        end else if (w_start) begin
            w_state_nx = S_CMD;
        end else if (w_cs_s) begin
            w_state_nx = S_IDLE;
        end else if (w_take) begin
            case (r_state)
                S_CMD: begin
                    if (w_op == OP_WRITE_AT || w_op == OP_READ_AT) w_state_nx = S_ADDR_HI;
                    else if (w_op == OP_WRITE_NEXT)                 w_state_nx = S_DATA;
                    else if (w_op == OP_READ_NEXT) begin
                        w_state_nx = S_BUS;
                        w_issue    = 1'b1;
                        w_iss_addr = w_next_addr;
                    end else                                        w_state_nx = S_DONE;
                end
                S_ADDR_HI: w_state_nx = S_ADDR_LO;
                S_ADDR_LO: begin
                    if (r_wr) w_state_nx = S_DATA;
                    else begin
                        w_state_nx = S_BUS;
                        w_issue    = 1'b1;
                        w_iss_addr = {r_tmp[ADDR_WIDTH-1:8], spi_rx_byte};
                    end
                end
                S_DATA: begin
                    w_state_nx = S_BUS;
                    w_issue    = 1'b1;
                    w_iss_rd   = 1'b0;
                    w_iss_addr = r_at ? r_tmp : w_next_addr;
                end
                default: ;
            endcase
        end
    end

    // Address bytes collect in r_tmp so an aborted command leaves bus_addr intact.
    always_ff @(posedge sys_clk or posedge reset)
        if (reset) begin
            r_cs_d    <= 1'b1;
            r_tmp     <= '0;
            r_at      <= 1'b0;
            r_wr      <= 1'b0;
            r_req     <= 1'b0;
            r_rw_b    <= 1'b1;
            r_addr    <= '0;
            r_wr_data <= 8'h00;
            r_tx      <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            r_cs_d <= w_cs_s;
            if (w_take && r_state == S_CMD) begin
                r_tmp[ADDR_WIDTH-1] <= spi_rx_byte[0];
                r_at                <= (w_op == OP_WRITE_AT) || (w_op == OP_READ_AT);
                r_wr                <= (w_op == OP_WRITE_AT) || (w_op == OP_WRITE_NEXT);
            end
            if (w_take && r_state == S_ADDR_HI) r_tmp[15:8] <= spi_rx_byte;
            if (w_take && r_state == S_ADDR_LO) r_tmp[7:0]  <= spi_rx_byte;
            if (w_issue) begin
                r_req  <= 1'b1;
                r_addr <= w_iss_addr;
                r_rw_b <= w_iss_rd;
                if (!w_iss_rd) r_wr_data <= spi_rx_byte;
            end else if (bus_ack && r_req) begin
                r_req <= 1'b0;
                if (r_rw_b) r_tx <= bus_rd_data;
            end
            if (w_start)                 r_overrun <= 1'b0;
            else if (spi_valid && r_req) r_overrun <= 1'b1;
        end

    assign spi_tx_byte = r_tx;
    assign bus_addr    = r_addr;
    assign bus_wr_data = r_wr_data;
    assign bus_rw_b    = r_rw_b;
    assign bus_req     = r_req;
    assign busy        = r_req;
    assign overrun     = r_overrun;
endmodule

// File: tb/tb_spi_cmd.sv
// tb_spi_cmd: directed and randomized command frames checked against an
// address/data model derived from the command set.
module tb_spi_cmd;
    logic        sys_clk = 1'b0, reset = 1'b1, spi_cs_n = 1'b1, spi_valid = 1'b0;
    logic [7:0]  spi_rx_byte = 8'h00, bus_rd_data = 8'h00;
    logic        bus_ack = 1'b0;
    logic [7:0]  spi_tx_byte, bus_wr_data;
    logic [16:0] bus_addr;
    logic        bus_rw_b, bus_req, busy, overrun;
    int          checks = 0, failures = 0;
    int          model_addr = 0;
    localparam int MASK = 32'h1FFFF;

    spi_cmd #(.ADDR_WIDTH(17)) dut (
        .sys_clk(sys_clk), .reset(reset), .spi_cs_n(spi_cs_n),
        .spi_rx_byte(spi_rx_byte), .spi_valid(spi_valid), .spi_tx_byte(spi_tx_byte),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rw_b(bus_rw_b),
        .bus_req(bus_req), .bus_ack(bus_ack), .bus_rd_data(bus_rd_data),
        .busy(busy), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        spi_rx_byte = b;
        spi_valid   = 1'b1;
        @(posedge sys_clk); #1;
        spi_valid   = 1'b0;
    endtask

    task automatic cs_set(input logic v);
        @(posedge sys_clk); #1;
        spi_cs_n = v;
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    task automatic ack(input logic [7:0] rd);
        bus_ack     = 1'b1;
        bus_rd_data = rd;
        @(posedge sys_clk); #1;
        bus_ack     = 1'b0;
    endtask

    task automatic bus_cycle(input logic exp_rw, input int exp_addr, input logic [7:0] exp_data,
                             input logic [7:0] rd, input int dly);
        int n = 0;
        while (!bus_req && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("req_seen", bus_req, 1);
        chk("rw", bus_rw_b, exp_rw);
        chk("addr", bus_addr, exp_addr);
        if (!exp_rw) chk("wdata", bus_wr_data, exp_data);
        repeat (dly) @(posedge sys_clk);
        #1;
        chk("req_hold", bus_req, 1);
        ack(rd);
        chk("req_drop", bus_req, 0);
        chk("busy_drop", busy, 0);
        if (exp_rw) chk("tx", spi_tx_byte, rd);
    endtask

    task automatic run_cmd(input logic [31:0] bytes, input int n, input logic rw, input int addr,
                           input logic [7:0] data, input logic [7:0] rd, input int dly);
        for (int k = 0; k < n; k++) begin
            send_byte(bytes[31-8*k -: 8]);
            chk(k == n - 1 ? "req_latency" : "req_early", bus_req, k == n - 1);
        end
        bus_cycle(rw, addr, data, rd, dly);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1 reset = 1'b0;
        chk("rst_req", bus_req, 0);
        chk("rst_rw", bus_rw_b, 1);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wr_data, 0);
        chk("rst_tx", spi_tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);

        cs_set(0);
        model_addr = 32'h18000;
        run_cmd(32'h8180_00A5, 4, 0, model_addr, 8'hA5, 8'h00, 2);
        model_addr = 32'h01234;
        run_cmd(32'h4012_3400, 3, 1, model_addr, 8'h00, 8'h5A, 3);
        chk("tx_hold", spi_tx_byte, 8'h5A);
        model_addr = 32'h1FFFE;
        run_cmd(32'h41FF_FE00, 3, 1, model_addr, 8'h00, 8'h11, 1);
        model_addr = (model_addr + 1) & MASK;
        run_cmd(32'h0000_0000, 1, 1, model_addr, 8'h00, 8'h22, 0);
        model_addr = (model_addr + 1) & MASK;
        run_cmd(32'h0000_0000, 1, 1, model_addr, 8'h00, 8'h33, 2);
        chk("wrap_addr", bus_addr, 0);
        cs_set(1);

        cs_set(0);
        send_byte(8'h81); chk("part_req0", bus_req, 0);
        send_byte(8'h33); chk("part_req1", bus_req, 0);
        cs_set(1);
        chk("part_req2", bus_req, 0);
        cs_set(0);
        model_addr = (model_addr + 1) & MASK;
        run_cmd(32'h2011_0000, 2, 0, model_addr, 8'h11, 8'h00, 1);

        model_addr = 32'h00010;
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h10);
        chk("ovr_req", bus_req, 1);
        chk("ovr_addr", bus_addr, model_addr);
        send_byte(8'h00);
        chk("ovr_set", overrun, 1);
        chk("ovr_req_hold", bus_req, 1);
        repeat (15) @(posedge sys_clk);
        #1;
        ack(8'h77);
        chk("ovr_ack_req", bus_req, 0);
        chk("ovr_tx", spi_tx_byte, 8'h77);
        repeat (5) @(posedge sys_clk);
        #1;
        chk("dropped_byte", bus_req, 0);
        chk("ovr_sticky", overrun, 1);

        model_addr = (model_addr + 1) & MASK;
        send_byte(8'h00);
        chk("cs_req", bus_req, 1);
        cs_set(1);
        chk("cs_req_hold", bus_req, 1);
        chk("cs_addr", bus_addr, model_addr);
        ack(8'h3C);
        chk("cs_ack_req", bus_req, 0);
        chk("cs_tx", spi_tx_byte, 8'h3C);
        send_byte(8'h00);
        chk("idle_ignore", bus_req, 0);
        chk("ovr_pre_frame", overrun, 1);
        cs_set(0);
        chk("ovr_clear", overrun, 0);

        send_byte(8'h00);
        chk("pre_rst_req", bus_req, 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_req", bus_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rw", bus_rw_b, 1);
        chk("arst_addr", bus_addr, 0);
        chk("arst_wdata", bus_wr_data, 0);
        chk("arst_tx", spi_tx_byte, 0);
        chk("arst_ovr", overrun, 0);
        @(posedge sys_clk); #1 reset = 1'b0;
        model_addr = 0;
        cs_set(1);

        cs_set(0);
        send_byte(8'hF0); chk("bad_op0", bus_req, 0);
        send_byte(8'h00); chk("bad_op1", bus_req, 0);
        send_byte(8'h40); chk("bad_op2", bus_req, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("bad_op_busy", busy, 0);
        cs_set(1);

        cs_set(0);
        for (int i = 0; i < 24; i++) begin
            int         op, a, dly;
            logic [7:0] d, rd;
            op  = $urandom_range(0, 3);
            a   = $urandom_range(0, MASK);
            d   = 8'($urandom);
            rd  = 8'($urandom);
            dly = $urandom_range(0, 4);
            case (op)
                0: begin
                    model_addr = a;
                    run_cmd({7'h40, a[16], a[15:0], d}, 4, 0, model_addr, d, rd, dly);
                end
                1: begin
                    model_addr = a;
                    run_cmd({7'h20, a[16], a[15:0], 8'h00}, 3, 1, model_addr, d, rd, dly);
                end
                2: begin
                    model_addr = (model_addr + 1) & MASK;
                    run_cmd({8'h20, d, 16'h0000}, 2, 0, model_addr, d, rd, dly);
                end
                default: begin
                    model_addr = (model_addr + 1) & MASK;
                    run_cmd(32'h0, 1, 1, model_addr, d, rd, dly);
                end
            endcase
        end
        cs_set(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
